commit_trace_checker: RTL and testbench

COMMIT_TRACE_CHECKER -- requirements
Module: commit_trace_checker

---
 rtl/commit_trace_checker.sv | 160 ++++++++++++++++
 tb/tb_commit_trace_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// Commit-trace checker: compares retiring register writes and stores against a
// preloaded FIFO of expected records and reports a sticky pass/fail verdict.
module commit_trace_checker #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_wr_en,
    input  logic [96:0]      exp_wr_data,
    input  logic             start,
    input  logic             done,
    input  logic             reg_we,
    input  logic             mem_we,
    input  logic [31:0]      ev_pc,
    input  logic [4:0]       ev_rd,
    input  logic [31:0]      ev_addr,
    input  logic [31:0]      ev_data,
    output logic             exp_full,
    output logic             exp_empty,
    output logic [1:0]       state,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] match_count,
    output logic [31:0]      fail_pc
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_PASS = 2'b10,
        S_FAIL = 2'b11
    } state_t;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_MISMATCH = 3'd1;
    localparam logic [2:0] E_UNEXP    = 3'd2;
    localparam logic [2:0] E_MISSING  = 3'd3;
    localparam logic [2:0] E_BOTH     = 3'd4;
    localparam logic [2:0] E_OVF      = 3'd5;

    logic [96:0]      mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, occ, occ_after;
    state_t           state_q, state_d;
    logic [2:0]       err_q, err_d;
    logic [31:0]      fail_pc_q, fail_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, fail_q;

    logic        active, push_req, push_en, pop_en, overflow;
    logic        ev_any, ev_both, is_match;
    logic [96:0] head;
    logic [31:0] ev_key;

    assign exp_empty = (wr_ptr_q == rd_ptr_q);
    assign exp_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occ       = wr_ptr_q - rd_ptr_q;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    assign ev_any   = reg_we | mem_we;
    assign ev_both  = reg_we & mem_we;
    assign ev_key   = mem_we ? ev_addr : {27'd0, ev_rd};
    assign is_match = (head[96] == mem_we) && (head[95:64] == ev_pc) &&
                      (head[63:32] == ev_key) && (head[31:0] == ev_data);

    assign active   = (state_q == S_LOAD) || (state_q == S_RUN);
    assign push_req = exp_wr_en && active;
    assign pop_en   = (state_q == S_RUN) && ev_any && !ev_both && !exp_empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign push_en  = push_req && (!exp_full || pop_en);
    assign overflow = push_req && exp_full && !pop_en;
    assign occ_after = occ + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        fail_pc_d = fail_pc_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_LOAD: begin
                if (overflow) begin
                    state_d   = S_FAIL;
                    err_d     = E_OVF;
                    fail_pc_d = 32'd0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_both) begin
                    state_d   = S_FAIL;
                    err_d     = E_BOTH;
                    fail_pc_d = ev_pc;
                end else if (ev_any && exp_empty) begin
                    state_d   = S_FAIL;
                    err_d     = E_UNEXP;
                    fail_pc_d = ev_pc;
                end else if (ev_any && !is_match) begin
                    state_d   = S_FAIL;
                    err_d     = E_MISMATCH;
                    fail_pc_d = ev_pc;
                end else begin
                    if (ev_any && cnt_q != {CNT_W{1'b1}})
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Done is judged on the occupancy left after this cycle's event.
                    if (overflow) begin
                        state_d   = S_FAIL;
                        err_d     = E_OVF;
                        fail_pc_d = 32'd0;
                    end else if (done) begin
                        if (occ_after == '0) begin
                            state_d = S_PASS;
                        end else begin
                            state_d   = S_FAIL;
                            err_d     = E_MISSING;
                            fail_pc_d = 32'd0;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= E_NONE;
            fail_pc_q <= 32'd0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            fail_pc_q <= fail_pc_d;
            cnt_q     <= cnt_d;
            pass_q    <= (state_d == S_PASS);
            fail_q    <= (state_d == S_FAIL);
            if (push_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop_en)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !reset) mem_q[wr_ptr_q[AW-1:0]] <= exp_wr_data;
    end

    assign state       = state_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign err_code    = err_q;
    assign match_count = cnt_q;
    assign fail_pc     = fail_pc_q;
endmodule

// File: tb/tb_commit_trace_checker.sv
// Scoreboard bench for commit_trace_checker: expected observations are queued
// as each cycle's stimulus is driven and compared after the clock edge.
module tb_commit_trace_checker;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    localparam logic [1:0] LOAD = 2'b00, RUN = 2'b01, PASS = 2'b10, FAILS = 2'b11;

    logic             clk = 1'b0;
    logic             reset, exp_wr_en, start, done, reg_we, mem_we;
    logic [96:0]      exp_wr_data;
    logic [31:0]      ev_pc, ev_addr, ev_data;
    logic [4:0]       ev_rd;
    logic             exp_full, exp_empty, pass, fail;
    logic [1:0]       state;
    logic [2:0]       err_code;
    logic [CNT_W-1:0] match_count;
    logic [31:0]      fail_pc;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [2:0]  err;
        logic [1:0]  cnt;
        logic [31:0] pc;
        logic        emp;
        logic        full;
    } obs_t;
    obs_t sb[$];

    commit_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .exp_wr_en(exp_wr_en), .exp_wr_data(exp_wr_data),
        .start(start), .done(done), .reg_we(reg_we), .mem_we(mem_we),
        .ev_pc(ev_pc), .ev_rd(ev_rd), .ev_addr(ev_addr), .ev_data(ev_data),
        .exp_full(exp_full), .exp_empty(exp_empty), .state(state),
        .pass(pass), .fail(fail), .err_code(err_code),
        .match_count(match_count), .fail_pc(fail_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors so far %0d", n_errs);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [96:0] rrec(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        return {1'b0, pc, 27'd0, rd, d};
    endfunction

    function automatic logic [96:0] srec(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        return {1'b1, pc, a, d};
    endfunction

    task automatic clr();
        reset = 0; exp_wr_en = 0; exp_wr_data = '0; start = 0; done = 0;
        reg_we = 0; mem_we = 0; ev_pc = '0; ev_rd = '0; ev_addr = '0; ev_data = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        clr();
    endtask

    // Queue the expected observation, clock once, then pop and compare.
    task automatic tick_chk(input string tag, input logic [1:0] st, input logic [2:0] err,
                            input logic [1:0] cnt, input logic [31:0] pc,
                            input logic emp, input logic full);
        obs_t o;
        o.tag = tag; o.st = st; o.err = err; o.cnt = cnt; o.pc = pc; o.emp = emp; o.full = full;
        sb.push_back(o);
        @(posedge clk); #1;
        clr();
        o = sb.pop_front();
        chk({o.tag, ".state"}, 64'(state), 64'(o.st));
        chk({o.tag, ".err"},   64'(err_code), 64'(o.err));
        chk({o.tag, ".cnt"},   64'(match_count), 64'(o.cnt));
        chk({o.tag, ".pc"},    64'(fail_pc), 64'(o.pc));
        chk({o.tag, ".empty"}, 64'(exp_empty), 64'(o.emp));
        chk({o.tag, ".full"},  64'(exp_full), 64'(o.full));
        chk({o.tag, ".pass"},  64'(pass), 64'(o.st == PASS));
        chk({o.tag, ".fail"},  64'(fail), 64'(o.st == FAILS));
    endtask

    task automatic push(input logic [96:0] r);
        exp_wr_en = 1; exp_wr_data = r;
    endtask

    task automatic evr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        reg_we = 1; ev_pc = pc; ev_rd = rd; ev_data = d;
    endtask

    task automatic evs(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        mem_we = 1; ev_pc = pc; ev_addr = a; ev_data = d;
    endtask

    task automatic do_reset();
        reset = 1;
        tick_chk("reset", LOAD, 3'd0, 2'd0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic load3();
        push(rrec(32'h00, 5'd5, 32'd7));   tick();
        push(rrec(32'h04, 5'd6, 32'd9));   tick();
        push(srec(32'h08, 32'h100, 32'd16));
        tick_chk("load3", LOAD, 3'd0, 2'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        clr();
        do_reset();

        // Full matching run
        load3();
        start = 1;                           tick_chk("t1.start", RUN, 0, 0, 0, 0, 0);
        evr(32'h00, 5'd5, 32'd7);            tick_chk("t1.ev1", RUN, 0, 1, 0, 0, 0);
        evr(32'h04, 5'd6, 32'd9);            tick_chk("t1.ev2", RUN, 0, 2, 0, 0, 0);
        evs(32'h08, 32'h100, 32'd16);        tick_chk("t1.ev3", RUN, 0, 3, 0, 1, 0);
        done = 1;                            tick_chk("t1.done", PASS, 0, 3, 0, 1, 0);
        push(rrec(32'h0, 5'd1, 32'd1));      tick_chk("t1.frozen", PASS, 0, 3, 0, 1, 0);

        // Data mismatch on second event
        do_reset();
        load3();
        start = 1;                           tick();
        evr(32'h00, 5'd5, 32'd7);            tick_chk("t2.ev1", RUN, 0, 1, 0, 0, 0);
        evr(32'h04, 5'd6, 32'd10);           tick_chk("t2.mis", FAILS, 1, 1, 32'h04, 0, 0);
        evs(32'h08, 32'h100, 32'd16);        tick_chk("t2.frozen", FAILS, 1, 1, 32'h04, 0, 0);

        // Missing events at done
        do_reset();
        push(rrec(32'h00, 5'd5, 32'd7));     tick();
        push(rrec(32'h04, 5'd6, 32'd9));     tick();
        start = 1;                           tick();
        evr(32'h00, 5'd5, 32'd7);            tick();
        done = 1;                            tick_chk("t3.done", FAILS, 3, 1, 0, 0, 0);

        // Overflow in LOAD
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(rrec(32'(i * 4), 5'(i), 32'(i))); tick();
        end
        push(rrec(32'h40, 5'd9, 32'd9));     tick_chk("t4.ovf", FAILS, 5, 0, 0, 0, 1);

        // Push on full with matching pop, saturation, done with last event
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(rrec(32'h10 + 32'(i * 4), 5'(i + 1), 32'(100 + i))); tick();
        end
        start = 1;                           tick_chk("t5.start", RUN, 0, 0, 0, 0, 1);
        evr(32'h10, 5'd1, 32'd100);
        push(srec(32'h20, 32'h200, 32'hdead)); tick_chk("t5.pushpop", RUN, 0, 1, 0, 0, 1);
        evr(32'h14, 5'd2, 32'd101);          tick_chk("t5.ev2", RUN, 0, 2, 0, 0, 0);
        evr(32'h18, 5'd3, 32'd102);          tick_chk("t5.ev3", RUN, 0, 3, 0, 0, 0);
        evr(32'h1c, 5'd4, 32'd103);          tick_chk("t5.sat", RUN, 0, 3, 0, 0, 0);
        evs(32'h20, 32'h200, 32'hdead);
        done = 1;                            tick_chk("t5.done", PASS, 0, 3, 0, 1, 0);

        // Event with FIFO empty
        do_reset();
        start = 1;                           tick();
        evr(32'h40, 5'd1, 32'd1);            tick_chk("t6.unexp", FAILS, 2, 0, 32'h40, 1, 0);

        // Both commit strobes at once; a full FIFO proves nothing was popped
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push(rrec(32'(i * 4), 5'(i), 32'(i))); tick();
        end
        start = 1;                           tick();
        evr(32'h00, 5'd0, 32'd0); mem_we = 1; tick_chk("t7.both", FAILS, 4, 0, 32'h00, 0, 1);

        // Reset mid-run dominates a coincident push and event
        do_reset();
        load3();
        start = 1;                           tick();
        evr(32'h00, 5'd5, 32'd7);            tick();
        evr(32'h04, 5'd6, 32'd9);            tick_chk("t8.two", RUN, 0, 2, 0, 0, 0);
        evs(32'h08, 32'h100, 32'd16);
        push(rrec(32'h50, 5'd2, 32'd2));
        reset = 1;                           tick_chk("t8.rst", LOAD, 0, 0, 0, 1, 0);
        evr(32'h60, 5'd3, 32'd3);            tick_chk("t8.loadev", LOAD, 0, 0, 0, 1, 0);
        push(rrec(32'h60, 5'd3, 32'd3));     tick();
        start = 1;                           tick();
        evr(32'h60, 5'd3, 32'd3);            tick_chk("t8.ev", RUN, 0, 1, 0, 1, 0);
        done = 1;                            tick_chk("t8.done", PASS, 0, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
